// File: rtl/sw_debounce_pkg.sv
// Shared state encoding and default settle time for the slide-switch debouncer.
package sw_debounce_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // 10 ms at 50 MHz
  localparam int unsigned SW_DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchroniser, hold-off counter, IDLE/COUNT FSM
// and registered rise/fall pulses aligned with the commit edge.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw,
  output logic sw_rise,
  output logic sw_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s0, s1;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sw_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0      <= 1'b0;
      s1      <= 1'b0;
      state   <= ST_IDLE;
      cnt     <= '0;
      sw      <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      s0      <= sw_raw;
      s1      <= s0;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sw      <= sw_nxt;
      sw_rise <= rise_nxt;
      sw_fall <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    sw_nxt    = sw;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (s1 != sw) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (s1 == sw) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          // s1 differs from sw here, so s1 alone gives the pulse direction
          sw_nxt    = s1;
          rise_nxt  = s1;
          fall_nxt  = ~s1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounces the board slide switches; also provides a sticky sw_valid flag
// once the post-reset settle time has elapsed.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_valid
);

  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(DEBOUNCE_CYCLES + 2);

  logic [CNT_W-1:0] timer;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_ch
      sw_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_bit (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw[g]),
        .sw      (sw[g]),
        .sw_rise (sw_rise[g]),
        .sw_fall (sw_fall[g])
      );
    end
  endgenerate

  // Timer saturates at SETTLE; sw_valid then rises on the same edge as a
  // channel held high through reset commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      sw_valid <= 1'b0;
    end else begin
      if (timer != SETTLE) timer <= timer + 1'b1;
      if (timer == SETTLE) sw_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with DEBOUNCE_CYCLES=4 (commit 7 edges after drive).
module tb_sw_debounce;

  typedef struct {
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] sw;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] sw_raw;
  logic [7:0] sw;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       sw_valid;

  int   checks;
  int   failures;
  int   cyc;
  exp_t q[$];

  sw_debounce #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .sw       (sw),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_valid (sw_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: any pulse is a DUT response and must match the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((sw_rise | sw_fall) != 8'h00) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d rise=%h fall=%h sw=%h required no pulse",
                   cyc, sw_rise, sw_fall, sw);
        end else begin
          e = q.pop_front();
          if (sw_rise !== e.rise || sw_fall !== e.fall || sw !== e.sw || cyc != e.cyc) begin
            failures++;
            $display("FAIL pulse cyc=%0d rise=%h fall=%h sw=%h required cyc=%0d rise=%h fall=%h sw=%h",
                     cyc, sw_rise, sw_fall, sw, e.cyc, e.rise, e.fall, e.sw);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] f, input logic [7:0] s);
    exp_t e;
    e.rise = r;
    e.fall = f;
    e.sw   = s;
    e.cyc  = cyc + 7;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sw_raw   = 8'h03;
    tick(3);
    chk("reset_sw", sw, 8'h00);
    chk("reset_rise", sw_rise, 8'h00);
    chk("reset_fall", sw_fall, 8'h00);
    chk("reset_valid", {7'd0, sw_valid}, 8'h00);

    // Startup: inputs high through reset commit together with sw_valid
    rst = 1'b0;
    push(8'h03, 8'h00, 8'h03);
    tick(6);
    chk("startup_valid_early", {7'd0, sw_valid}, 8'h00);
    tick(1);
    chk("startup_valid", {7'd0, sw_valid}, 8'h01);
    chk("startup_sw", sw, 8'h03);
    tick(4);

    // Clean edge
    sw_raw = 8'h00;
    push(8'h00, 8'h03, 8'h00);
    tick(10);
    sw_raw = 8'h01;
    push(8'h01, 8'h00, 8'h01);
    tick(10);
    chk("clean_sw", sw, 8'h01);

    // Bounce: only the final settled level commits
    sw_raw = 8'h00;
    push(8'h00, 8'h01, 8'h00);
    tick(10);
    sw_raw = 8'h01; tick(2);
    sw_raw = 8'h00; tick(2);
    sw_raw = 8'h01; tick(2);
    sw_raw = 8'h00; tick(2);
    sw_raw = 8'h01;
    push(8'h01, 8'h00, 8'h01);
    tick(10);
    chk("bounce_sw", sw, 8'h01);

    // Short glitch on bit 3
    sw_raw = 8'h09;
    tick(3);
    sw_raw = 8'h01;
    tick(10);
    chk("glitch_sw", sw, 8'h01);

    // Simultaneous opposite changes
    sw_raw = 8'h80;
    push(8'h80, 8'h01, 8'h80);
    tick(10);
    sw_raw = 8'h01;
    push(8'h01, 8'h80, 8'h01);
    tick(10);
    chk("simul_sw", sw, 8'h01);

    // Reset two cycles into COUNT
    sw_raw = 8'h00;
    push(8'h00, 8'h01, 8'h00);
    tick(10);
    sw_raw = 8'h05;
    tick(5);
    rst = 1'b1;
    #1;
    chk("midrst_sw", sw, 8'h00);
    chk("midrst_rise", sw_rise, 8'h00);
    chk("midrst_fall", sw_fall, 8'h00);
    chk("midrst_valid", {7'd0, sw_valid}, 8'h00);
    tick(2);
    rst = 1'b0;
    push(8'h05, 8'h00, 8'h05);
    tick(6);
    chk("midrst_sw_early", sw, 8'h00);
    tick(1);
    chk("midrst_sw_commit", sw, 8'h05);
    chk("midrst_valid_after", {7'd0, sw_valid}, 8'h01);
    tick(5);

    chk("scoreboard_empty", 8'(q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Synchronises and debounces the eight board slide switches before they reach the `counter` pattern block. Its `sw` output drives the `sw` input of `counter` directly. Each channel has a two-flop synchroniser, a per-channel hold-off counter and a two-state FSM. The block also emits one-cycle rise/fall pulses per channel and a sticky `sw_valid` flag once the post-reset settle time has elapsed.

## Interface
- `WIDTH`, 8: number of switch channels.
- `DEBOUNCE_CYCLES`, 500000: stable cycles needed to commit a change (10 ms at 50 MHz); legal range ≥1.
- `CNT_W`, 20: counter width; 2^CNT_W > DEBOUNCE_CYCLES+2 is required.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `sw_raw`  in  WIDTH  raw switch pins, asynchronous to `clk`.
- `sw`  out  WIDTH  debounced level; feeds `counter.sw`.
- `sw_rise`  out  WIDTH  one-cycle pulse when `sw[i]` commits 0→1.
- `sw_fall`  out  WIDTH  one-cycle pulse when `sw[i]` commits 1→0.
- `sw_valid`  out  1  sticky high once the startup settle time has elapsed.

## Operation
- Reset values: all outputs 0; sync flops 0; every FSM in IDLE; all counters 0.
- Each channel `i` is independent:
  - `s0 <= sw_raw[i]`, then `s1 <= s0`.
  - The FSM compares `s1` against the committed `sw[i]`.
- IDLE:
  - `s1 == sw[i]`: stay, `cnt = 0`.
  - `s1 != sw[i]`: go to COUNT, `cnt = 0`.
- COUNT:
  - `s1 == sw[i]` (bounce back): go to IDLE, `cnt = 0`, no pulse, `sw` unchanged.
  - Else if `cnt == DEBOUNCE_CYCLES-1`:
    - commit `sw[i] <= s1`;
    - pulse `sw_rise[i]` or `sw_fall[i]` for exactly one cycle, same edge as the commit;
    - go to IDLE, `cnt = 0`.
  - Else `cnt++`.
- `sw_rise[i]` and `sw_fall[i]` are never high together. Pulses default to 0 every cycle.
- Simultaneous changes on several channels commit and pulse independently, in the same cycle if their timing coincides.
- Startup timer: a single saturating counter starts after reset release. `sw_valid` rises when the timer reaches DEBOUNCE_CYCLES+2 and stays high until `rst`.
- Channels whose `sw_raw` is 1 through reset commit, and pulse `sw_rise`, on the same edge `sw_valid` rises.
- Reset mid-count: `rst` clears all state and outputs immediately (asynchronously). After release, debouncing restarts from scratch with no residual count.

## Timing
- Edge E0 is the first rising edge that captures a new stable `sw_raw` level:
  - E1: `s1` updates.
  - E2: FSM enters COUNT.
  - E(DEBOUNCE_CYCLES+2): `sw` commits and the pulse is asserted.
- Total latency is therefore DEBOUNCE_CYCLES+2 cycles.
- A bounce cancels the count. The latency is measured from the last bounce's capture edge.
- `sw_valid` asserts on the (DEBOUNCE_CYCLES+3)-th rising edge after `rst` deasserts.
- All outputs are registered; there are no combinational paths from `sw_raw`.

## Structure
- Shared package/header holds:
  - state encodings `ST_IDLE = 1'b0`, `ST_COUNT = 1'b1`;
  - default constant `SW_DEBOUNCE_CYCLES_DEFAULT = 500000`.
- Sub-module `sw_debounce_bit` contains one channel: synchroniser, counter, FSM and pulse logic. It has parameters `DEBOUNCE_CYCLES` and `CNT_W`.
- The top level instantiates `sw_debounce_bit` WIDTH times via `generate` and holds the startup timer and `sw_valid`.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4.
- **Clean edge:** `sw_raw = 8'h00` → `8'h01` held → `sw = 8'h01` 6 cycles after the capture edge; `sw_rise[0]` high exactly 1 cycle; `sw_fall = 0`.
- **Bounce:** `sw_raw[0]` toggles 1,0,1,0,1 with 2 cycles per level, then holds 1 → exactly one `sw_rise[0]`, committed 6 cycles after the final capture edge; no intermediate commit.
- **Short glitch:** `sw_raw[3]` pulses high for 3 cycles from `sw = 0` → `sw[3]` stays 0; no pulses.
- **Simultaneous:** from `sw = 8'h80`, `sw_raw` becomes `8'h01` in one cycle → `sw = 8'h01`; `sw_rise[0]` and `sw_fall[7]` asserted in the same cycle.
- **Startup:** `sw_raw = 8'h03` held through reset → `sw_valid`, `sw = 8'h03` and `sw_rise = 8'h03` all assert on the 7th edge after release.
- **Reset mid-count:** assert `rst` 2 cycles into COUNT → all outputs 0 immediately; after release with `sw_raw` still changed, commit occurs a full 6 cycles after the first capture edge.
